mem_stage_mc: RTL
=================

# mem_stage_mc

Parametrised memory pipeline stage for the MIPS pipeline. It sits between the EX/MEM and MEM/WB registers and drives a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and extracts and extends sub-word loads. It generates byte-lane stores, traps misaligned and timed-out accesses, and publishes forwarding data for both the in-flight MEM instruction and the MEM/WB register.

## Interface
Parameters:
- DATA_W, 32, data and address width; must be 32 or 64.
- TIMEOUT, 15, maximum cycles an access may wait for an ack; must be ≥ 1.
- LANES, DATA_W/8, derived (localparam): number of byte lanes.

Ports:
- clock  in  1  single clock; everything is on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX/MEM holds a real instruction; 0 means bubble.
- in_pc  in  DATA_W  instruction PC.
- in_alu_result  in  DATA_W  effective address, or the ALU result.
- in_store_data  in  DATA_W  store source register value.
- in_mem_read, in_mem_write  in  1 each  load / store; never both 1.
- in_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = double (only legal when DATA_W = 64).
- in_signed  in  1  sign-extend the load.
- in_reg_write  in  1  instruction writes a register.
- in_write_id  in  5  destination register.
- stall  out  1  freeze EX/MEM and all earlier stages.
- mem_req  out  1  access request.
- mem_we  out  1  write request.
- mem_addr  out  DATA_W  lane-aligned address (low log2(LANES) bits zero).
- mem_be  out  LANES  byte enables.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- out_valid, out_pc, out_result, out_write_id, out_reg_write  out  registered MEM/WB fields.
- out_exc  out  2  exception code: 0 = none, 1 = misaligned, 2 = bus timeout.
- fwd_mem_id, fwd_mem_ready  out  5, 1  in-flight MEM forwarding.
- fwd_wb_id, fwd_wb_data  out  5, DATA_W  MEM/WB forwarding.

## Operation
- The memory op predicate is mem_op = in_valid & (in_mem_read | in_mem_write).
- Alignment: bytes = 1 << in_size, off = in_alu_result[log2(LANES)-1:0]. The access is misaligned when off mod bytes ≠ 0, or when bytes > LANES.
- Misaligned access: no mem_req is issued. It completes in 1 cycle with out_exc = 1, out_reg_write = 0 and out_result = 0.
- Store encoding:
  - mem_be = ((1 << bytes) - 1) << off.
  - mem_wdata = the low 8·bytes bits of in_store_data, replicated across all lanes.
- Load encoding: take the field mem_rdata[8·off +: 8·bytes], then zero- or sign-extend it to DATA_W according to in_signed.
- Result mux:
  - Loads take the extended value.
  - Non-memory instructions take in_alu_result.
  - Bubbles write out_result = 0.
- FSM has two states, IDLE and WAIT, plus a wait counter cnt.
  - IDLE with an aligned mem_op: mem_req = 1.
    - If mem_ack is 1: complete this cycle and stay in IDLE.
    - Otherwise: stall = 1, go to WAIT, cnt ← 1.
  - WAIT: mem_req = 1 and stall = 1.
    - If mem_ack is 1: complete, stall = 0 this cycle, go to IDLE.
    - Else if cnt == TIMEOUT: complete with out_exc = 2, out_reg_write = 0, stall = 0, go to IDLE.
    - Else: cnt ← cnt + 1.
  - Any non-mem_op instruction in IDLE completes in 1 cycle.
- On completion, MEM/WB loads the instruction's fields. While stall = 1, MEM/WB loads a bubble (out_valid = 0, out_reg_write = 0).
- mem_ack arriving while mem_req = 0 is ignored.
- In-flight forwarding:
  - fwd_mem_id = in_write_id when in_valid & in_reg_write, else 0.
  - fwd_mem_ready = 0 for a load that has not yet completed, else 1.
- MEM/WB forwarding: fwd_wb_id = out_write_id when out_reg_write, else 0. fwd_wb_data = out_result.

## Timing
- Reset clears the stage in the same edge:
  - State goes to IDLE and cnt to 0.
  - All out_* fields are 0 and out_valid = 0.
  - fwd_* outputs are 0; fwd_mem_ready follows its combinational rule.
- While reset = 1: mem_req = 0 and stall = 0, combinationally.
- Reset asserted during WAIT abandons the access. mem_req is 0 from that cycle, and the instruction never reaches MEM/WB.
- Latency:
  - Non-memory, misaligned, and zero-wait accesses (ack in the request cycle): 1 cycle.
  - An access acked N cycles after the request cycle: N + 1 cycles, with stall high for N cycles.
  - Timeout: TIMEOUT + 1 cycles.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are combinational from the EX/MEM inputs and the state. They hold stable during WAIT because upstream is frozen.
- All out_* signals are registered. All fwd_* signals are combinational.

## Test plan
- LB, address 0x1003, rdata 0x80FF_FF00, ack in the request cycle:
  - mem_be = 4'b1000, no stall.
  - Next cycle out_result = 0xFFFF_FF80.
  - Repeat as LBU: out_result = 0x0000_0080.
- SH, address 0x2002, store data 0x1234_ABCD, ack 3 cycles late:
  - mem_be = 4'b1100, mem_wdata = 0xABCD_ABCD.
  - stall is high for exactly 3 cycles; MEM/WB holds a bubble for 3 cycles, then the store completes.
- LW at address 0x1001: no mem_req; next cycle out_exc = 1, out_reg_write = 0.
- LW with ack never arriving, TIMEOUT = 15:
  - mem_req is high for 16 cycles, then drops.
  - out_exc = 2; stall falls in the final cycle.
- Reset raised in the 2nd WAIT cycle:
  - mem_req and stall drop immediately.
  - Next cycle out_valid = 0 and the state is IDLE.
  - A following ADD completes normally.
- LW to r8 stalled for 2 cycles:
  - fwd_mem_id = 8 with fwd_mem_ready = 0 while waiting.
  - After completion fwd_wb_id = 8 and fwd_wb_data = the loaded value.
  - A bubble input gives fwd_mem_id = 0.

Source files
------------

// File: rtl/mem_stage_mc.sv
// MIPS memory pipeline stage: drives a req/ack data memory, stalls upstream while an access
// is outstanding, formats sub-word loads/stores and traps misaligned or timed-out accesses.
module mem_stage_mc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    input  logic                  in_reg_write,
    input  logic [4:0]            in_write_id,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_result,
    output logic [4:0]            out_write_id,
    output logic                  out_reg_write,
    output logic [1:0]            out_exc,
    output logic [4:0]            fwd_mem_id,
    output logic                  fwd_mem_ready,
    output logic [4:0]            fwd_wb_id,
    output logic [DATA_W-1:0]     fwd_wb_data
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_mem_op;
    logic [OFF_W-1:0]   w_off;
    logic [3:0]         w_bytes;
    logic [3:0]         w_bm1;
    logic               w_misal;
    logic               w_req;
    logic               w_stall;
    logic               w_done;
    logic               w_timeout;

    logic [DATA_W-1:0]  w_field;
    logic [6:0]         w_nbits;
    logic [IDX_W-1:0]   w_msb;
    logic [DATA_W-1:0]  w_load;
    logic [LANES-1:0]   w_be;
    logic [DATA_W-1:0]  w_wdata;

    logic [1:0]         w_exc;
    logic [DATA_W-1:0]  w_result;
    logic               w_rw;

    logic               r_valid;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_result;
    logic [4:0]         r_write_id;
    logic               r_reg_write;
    logic [1:0]         r_exc;

    // Access decode and alignment check
    assign w_mem_op = in_valid & (in_mem_read | in_mem_write);
    assign w_off    = in_alu_result[OFF_W-1:0];
    assign w_bytes  = 4'b0001 << in_size;
    assign w_bm1    = w_bytes - 4'd1;
    assign w_misal  = ((4'(w_off) & w_bm1) != 4'd0) || (w_bytes > 4'(LANES));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Handshake FSM: reset forces request and stall low combinationally
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && !w_misal) begin
                        w_req = 1'b1;
                        if (mem_ack) begin
                            w_done = 1'b1;
                        end else begin
                            w_stall     = 1'b1;
                            w_state_nxt = S_WAIT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end else begin
                        w_done = 1'b1;
                    end
                end
                S_WAIT: begin
                    w_req = 1'b1;
                    if (mem_ack) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        w_done      = 1'b1;
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_stall   = 1'b1;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Store byte enables and lane-replicated store data
    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        if (w_req) begin
            for (int i = 0; i < LANES; i++) begin
                w_be[i] = (7'(i) >= 7'(w_off)) && (7'(i) < 7'(w_off) + 7'(w_bytes));
                w_wdata[8*i +: 8] = in_store_data[8*int'(3'(i) & 3'(w_bm1)) +: 8];
            end
        end
    end

    // Load field extraction with zero/sign extension
    assign w_field = mem_rdata >> {w_off, 3'b000};
    assign w_nbits = {w_bytes, 3'b000};
    assign w_msb   = IDX_W'(w_nbits - 7'd1);

    always_comb begin
        w_load = '0;
        for (int b = 0; b < DATA_W; b++) begin
            if (7'(b) < w_nbits) begin
                w_load[b] = w_field[b];
            end else begin
                w_load[b] = in_signed & w_field[w_msb];
            end
        end
    end

    always_comb begin
        w_exc = 2'd0;
        if (w_timeout) begin
            w_exc = 2'd2;
        end else if (w_mem_op && w_misal) begin
            w_exc = 2'd1;
        end
        w_rw     = in_valid & in_reg_write & (w_exc == 2'd0);
        w_result = '0;
        if (in_valid && (w_exc == 2'd0)) begin
            w_result = in_mem_read ? w_load : in_alu_result;
        end
    end

    // MEM/WB register: loads a bubble whenever the instruction has not completed
    always_ff @(posedge clock) begin
        if (reset || !w_done) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_result    <= '0;
            r_write_id  <= '0;
            r_reg_write <= 1'b0;
            r_exc       <= 2'd0;
        end else begin
            r_valid     <= in_valid;
            r_pc        <= in_pc;
            r_result    <= w_result;
            r_write_id  <= in_write_id;
            r_reg_write <= w_rw;
            r_exc       <= w_exc;
        end
    end

    assign stall         = w_stall;
    assign mem_req       = w_req;
    assign mem_we        = w_req & in_mem_write;
    assign mem_addr      = {in_alu_result[DATA_W-1:OFF_W], OFF_W'(0)};
    assign mem_be        = w_be;
    assign mem_wdata     = w_wdata;

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_result    = r_result;
    assign out_write_id  = r_write_id;
    assign out_reg_write = r_reg_write;
    assign out_exc       = r_exc;

    assign fwd_mem_id    = (!reset && in_valid && in_reg_write) ? in_write_id : 5'd0;
    assign fwd_mem_ready = !(w_mem_op && in_mem_read && !w_done);
    assign fwd_wb_id     = r_reg_write ? r_write_id : 5'd0;
    assign fwd_wb_data   = r_result;

endmodule
